// File: rtl/serial_addsub_nbit.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, carry registered between chunks.
// Optional OVF/ZERO/NEG flag logic is enabled by defining ADDSUB_FLAGS_EN.
module serial_addsub_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SUB,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             C_OUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG,
  output logic [1:0]       dbg_state
);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("serial_addsub_nbit: CHUNK must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Input side transfers only in IDLE; output side holds everything stable in DONE until OUT_READY.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             sub_q, carry_q, c_out_q;
  logic [CHUNK-1:0] x_c, y_c, y_eff, s_c;
  logic             c_nx, last;

  assign last = (state_q == RUN) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign dbg_state = state_q;

  // Operands shift right each RUN cycle so the current chunk is always the low CHUNK bits.
  // Subtraction adds ~Y with the borrow kept as an inverted carry.
  assign x_c   = x_q[CHUNK-1:0];
  assign y_c   = y_q[CHUNK-1:0];
  assign y_eff = sub_q ? ~y_c : y_c;
  assign {c_nx, s_c} = {1'b0, x_c} + {1'b0, y_eff} + {{CHUNK{1'b0}}, carry_q};

  generate
    if (CHUNK == WIDTH) begin : g_single
      assign x_nx = '0;
      assign y_nx = '0;
      assign z_nx = s_c;
    end else begin : g_multi
      assign x_nx = {{CHUNK{1'b0}}, x_q[WIDTH-1:CHUNK]};
      assign y_nx = {{CHUNK{1'b0}}, y_q[WIDTH-1:CHUNK]};
      assign z_nx = {s_c, z_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (IN_VALID) begin
        x_q     <= X;
        y_q     <= Y;
        sub_q   <= SUB;
        carry_q <= C_IN ^ SUB;
        cnt_q   <= '0;
      end
    end else if (state_q == RUN) begin
      x_q     <= x_nx;
      y_q     <= y_nx;
      z_q     <= z_nx;
      carry_q <= c_nx;
      cnt_q   <= last ? '0 : cnt_q + 1'b1;
      if (last) c_out_q <= c_nx ^ sub_q;
    end
  end

  assign Z     = z_q;
  assign C_OUT = c_out_q;

`ifdef ADDSUB_FLAGS_EN
  logic nz_q, nz_d, ovf_q, zero_q, neg_q;

  // Zero detect accumulates one chunk OR per cycle; the first chunk restarts it.
  assign nz_d = ((cnt_q == '0) ? 1'b0 : nz_q) | (|s_c);

  always_ff @(posedge CLK) begin
    if (RST) begin
      nz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == RUN) begin
      nz_q <= nz_d;
      if (last) begin
        zero_q <= ~nz_d;
        neg_q  <= s_c[CHUNK-1];
        ovf_q  <= (sub_q ? (x_c[CHUNK-1] != y_c[CHUNK-1]) : (x_c[CHUNK-1] == y_c[CHUNK-1]))
                  && (s_c[CHUNK-1] != x_c[CHUNK-1]);
      end
    end
  end

  assign OVF  = ovf_q;
  assign ZERO = zero_q;
  assign NEG  = neg_q;
`else
  assign OVF  = 1'b0;
  assign ZERO = 1'b0;
  assign NEG  = 1'b0;
`endif

endmodule
